led_pattern_gen: RTL

Multi-channel, parametrised successor to the single-output blinker. Drives `CHANNELS` LED outputs from a shared tick prescaler; each channel is independently configured at run time for off, on, continuous blink with programmable period/duty, or a counted burst that stops and signals completion. Sits between board LEDs and any controller (UART command decoder, test sequencer) that writes per-channel configuration.

---
 rtl/led_pattern_gen_if.sv | 20 ++
 rtl/led_pattern_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen_if.sv
// Configuration bus for led_pattern_gen: one write strobe plus the channel
// index and the per-channel fields it loads.
interface led_pattern_gen_if #(
   parameter int CNT_W = 8
);
   logic             cfg_we;
   logic [3:0]       cfg_ch;
   logic [1:0]       cfg_mode;
   logic [CNT_W-1:0] cfg_period;
   logic [CNT_W-1:0] cfg_duty;
   logic [7:0]       cfg_count;

   modport master (
      output cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_duty, cfg_count
   );

   modport slave (
      input cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_duty, cfg_count
   );
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: CHANNELS independent LED drivers sharing one phase-tick
// prescaler. Each channel is off, on, blinking (period/duty in ticks) or
// running a counted burst that ends idle with a one-cycle done pulse.
// LED and done are registered; both reflect channel state one edge later.
module led_pattern_gen #(
   parameter int TICK_DIV = 50_000,
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   led_pattern_gen_if.slave    cfg,
   output logic [CHANNELS-1:0] LED,
   output logic [CHANNELS-1:0] done
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
   localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
   localparam logic [PRE_W-1:0] PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_BURST = 2'd3
   } mode_e;

   // shared prescaler
   logic [PRE_W-1:0]    pre_r;
   logic                tick_s;

   // per-channel configuration and run state
   mode_e               mode_r   [CHANNELS];
   logic [CNT_W-1:0]    period_r [CHANNELS];
   logic [CNT_W-1:0]    duty_r   [CHANNELS];
   logic [7:0]          count_r  [CHANNELS];
   logic [CNT_W-1:0]    phase_r  [CHANNELS];
   logic [7:0]          burst_r  [CHANNELS];
   logic [CHANNELS-1:0] idle_r;
   logic [CHANNELS-1:0] sent_r;   // done already issued for the current burst

   // registered outputs
   logic [CHANNELS-1:0] led_r;
   logic [CHANNELS-1:0] done_r;

   // per-channel decode
   logic [CHANNELS-1:0] wr_hit_s;
   logic [CHANNELS-1:0] wrap_s;
   logic [CHANNELS-1:0] blink_s;
   logic [CHANNELS-1:0] is_burst_s;
   logic [CHANNELS-1:0] deg_s;
   logic [CHANNELS-1:0] adv_s;
   logic [CHANNELS-1:0] last_s;
   logic [CHANNELS-1:0] drop_s;
   logic [CHANNELS-1:0] fin_s;
   logic [CHANNELS-1:0] led_s;
   logic [CHANNELS-1:0] done_s;

   // Phase tick: one cycle in every TICK_DIV, on the last prescaler count.
   always_comb begin
      tick_s = (pre_r == PRE_MAX);
   end

   // Free-running prescaler; configuration writes never touch it.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_r <= PRE_ZERO;
      end else if (tick_s) begin
         pre_r <= PRE_ZERO;
      end else begin
         pre_r <= pre_r + PRE_ONE;
      end
   end

   // Per-channel decode: write select, phase wrap, next LED level and the
   // three ways a burst can signal completion.
   always_comb begin
      wr_hit_s   = {CHANNELS{1'b0}};
      wrap_s     = {CHANNELS{1'b0}};
      blink_s    = {CHANNELS{1'b0}};
      is_burst_s = {CHANNELS{1'b0}};
      deg_s      = {CHANNELS{1'b0}};
      adv_s      = {CHANNELS{1'b0}};
      last_s     = {CHANNELS{1'b0}};
      drop_s     = {CHANNELS{1'b0}};
      fin_s      = {CHANNELS{1'b0}};
      led_s      = {CHANNELS{1'b0}};
      done_s     = {CHANNELS{1'b0}};
      for (int c = 0; c < CHANNELS; c++) begin
         // out-of-range channel indices simply never match
         wr_hit_s[c]   = cfg.cfg_we && (cfg.cfg_ch == 4'(c));
         wrap_s[c]     = tick_s && (period_r[c] != CNT_ZERO)
                         && (phase_r[c] >= (period_r[c] - CNT_ONE));
         blink_s[c]    = (period_r[c] != CNT_ZERO) && (phase_r[c] < duty_r[c]);
         is_burst_s[c] = (mode_r[c] == MODE_BURST);
         // a burst with nothing to do finishes straight away
         deg_s[c]      = is_burst_s[c] && !idle_r[c]
                         && ((count_r[c] == 8'd0) || (period_r[c] == CNT_ZERO));
         adv_s[c]      = is_burst_s[c] && !idle_r[c] && wrap_s[c];
         last_s[c]     = (burst_r[c] == (count_r[c] - 8'd1));

         case (mode_r[c])
            MODE_OFF:   led_s[c] = 1'b0;
            MODE_ON:    led_s[c] = 1'b1;
            MODE_BLINK: led_s[c] = blink_s[c];
            MODE_BURST: led_s[c] = !idle_r[c] && (count_r[c] != 8'd0) && blink_s[c];
            default:    led_s[c] = 1'b0;
         endcase

         // final falling edge inside the last period (duty shorter than period)
         drop_s[c] = is_burst_s[c] && !idle_r[c] && last_s[c] && led_r[c]
                     && !led_s[c] && (phase_r[c] != CNT_ZERO);
         // burst just went idle without an earlier drop (duty 0 or duty >= period)
         fin_s[c]  = is_burst_s[c] && idle_r[c] && !sent_r[c];
         done_s[c] = deg_s[c] || drop_s[c] || fin_s[c];
      end
   end

   // Channel state: writes reload a channel and restart it, otherwise the
   // phase advances on tick and bursts count completed periods.
   always_ff @(posedge clk) begin
      for (int c = 0; c < CHANNELS; c++) begin
         if (rst) begin
            mode_r[c]   <= MODE_OFF;
            period_r[c] <= CNT_ZERO;
            duty_r[c]   <= CNT_ZERO;
            count_r[c]  <= 8'd0;
            phase_r[c]  <= CNT_ZERO;
            burst_r[c]  <= 8'd0;
            idle_r[c]   <= 1'b0;
            sent_r[c]   <= 1'b0;
         end else if (wr_hit_s[c]) begin
            // a write on the tick cycle wins: phase restarts at 0 with no step
            mode_r[c]   <= mode_e'(cfg.cfg_mode);
            period_r[c] <= cfg.cfg_period;
            duty_r[c]   <= cfg.cfg_duty;
            count_r[c]  <= cfg.cfg_count;
            phase_r[c]  <= CNT_ZERO;
            burst_r[c]  <= 8'd0;
            idle_r[c]   <= 1'b0;
            sent_r[c]   <= 1'b0;
         end else begin
            if (tick_s) begin
               if (wrap_s[c] || (period_r[c] == CNT_ZERO)) begin
                  phase_r[c] <= CNT_ZERO;
               end else begin
                  phase_r[c] <= phase_r[c] + CNT_ONE;
               end
            end
            if (deg_s[c]) begin
               idle_r[c] <= 1'b1;
            end else if (adv_s[c] && ((burst_r[c] + 8'd1) == count_r[c])) begin
               idle_r[c] <= 1'b1;
            end
            if (adv_s[c]) begin
               burst_r[c] <= burst_r[c] + 8'd1;
            end
            if (done_s[c]) begin
               sent_r[c] <= 1'b1;
            end
         end
      end
   end

   // Output registers: LED level and the one-cycle completion pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         led_r  <= {CHANNELS{1'b0}};
         done_r <= {CHANNELS{1'b0}};
      end else begin
         led_r  <= led_s;
         done_r <= done_s;
      end
   end

   assign LED  = led_r;
   assign done = done_r;

endmodule
